// File: rtl/otter_mdu_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface otter_mdu_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, funct3, a, b, input  busy, done, result);
  modport slave  (input  start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/otter_mdu.sv
// RV32M multiply/divide unit: 32-iteration radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up folded into the final iteration.
module otter_mdu (
  input logic      clk,
  input logic      rst_n,
  otter_mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] d;    // multiplicand or divisor magnitude
    logic        neg;  // negate final product / quotient / remainder
  } op_t;

  state_t      state;
  op_t         op;
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic [31:0] result_q;

  logic        a_sgn, b_sgn, neg_in;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc_init, acc_nxt, prod;
  logic [32:0] sum, rtry, diff;
  logic [31:0] quo, rem, res_nxt;

  always_comb begin
    a_sgn = (bus.funct3 == 3'd1 || bus.funct3 == 3'd2 || bus.funct3 == 3'd4 ||
             bus.funct3 == 3'd6) && bus.a[31];
    b_sgn = (bus.funct3 == 3'd1 || bus.funct3 == 3'd4 || bus.funct3 == 3'd6) && bus.b[31];
    a_mag = a_sgn ? -bus.a : bus.a;
    b_mag = b_sgn ? -bus.b : bus.b;
    if (!bus.funct3[2])     neg_in = a_sgn ^ b_sgn;
    else if (bus.funct3[1]) neg_in = a_sgn;
    else                    neg_in = (a_sgn ^ b_sgn) && (bus.b != 32'd0); // x/0 stays all-ones
    acc_init = bus.funct3[2] ? {32'd0, a_mag} : {32'd0, b_mag};
  end

  always_comb begin
    sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op.d} : 33'd0);
    rtry = {acc[63:32], acc[31]};
    diff = rtry - {1'b0, op.d};
    if (!op.f3[2])                acc_nxt = {sum, acc[31:1]};
    else if (rtry >= {1'b0, op.d}) acc_nxt = {diff[31:0], acc[30:0], 1'b1};
    else                           acc_nxt = {rtry[31:0], acc[30:0], 1'b0};
    prod = op.neg ? -acc_nxt : acc_nxt;
    quo  = op.neg ? -acc_nxt[31:0]  : acc_nxt[31:0];
    rem  = op.neg ? -acc_nxt[63:32] : acc_nxt[63:32];
    case (op.f3)
      3'd0:          res_nxt = prod[31:0];
      3'd1, 3'd2, 3'd3: res_nxt = prod[63:32];
      3'd4, 3'd5:    res_nxt = quo;
      default:       res_nxt = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      result_q <= 32'd0;
      op       <= '0;
      acc      <= 64'd0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op    <= '{f3: bus.funct3, d: (bus.funct3[2] ? b_mag : a_mag), neg: neg_in};
          acc   <= acc_init;
          cnt   <= 6'd0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result_q <= res_nxt;
            state    <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == FIN);
  assign bus.result = result_q;
endmodule
